lattice_readout: RTL and testbench

LATTICE_READOUT -- requirements
Module: lattice_readout

---
 rtl/lattice_readout.sv | 211 +++++++++++++++++++++
 tb/tb_lattice_readout.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lattice_readout.sv
// Lattice frame readout.
// Streams one frame of 9-bank lattice cells out of BRAM in raster order.
// Each returned cell is shaded as density, |ux| or |uy| and queued in a
// 4-entry output FIFO behind a valid/ready handshake. Reads are credit
// limited, so every read in flight is guaranteed a FIFO slot.
module lattice_readout #(
  parameter  int HPIXELS    = 320,
  parameter  int VPIXELS    = 180,
  localparam int BRAM_DEPTH = HPIXELS * VPIXELS,
  localparam int BRAM_SIZE  = $clog2(BRAM_DEPTH),
  localparam int XW         = $clog2(HPIXELS),
  localparam int YW         = $clog2(VPIXELS)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [1:0]           mode_in,
  input  logic [8:0][7:0]      bram_data_in,
  output logic [BRAM_SIZE-1:0] addr_out,
  output logic [7:0]           pixel_out,
  output logic                 pixel_valid_out,
  input  logic                 pixel_ready_in,
  output logic [XW-1:0]        x_out,
  output logic [YW-1:0]        y_out,
  output logic                 busy_out,
  output logic                 frame_done_out
);

  // Bank order on bram_data_in.
  localparam int B_N  = 1;
  localparam int B_NE = 2;
  localparam int B_E  = 3;
  localparam int B_SE = 4;
  localparam int B_S  = 5;
  localparam int B_SW = 6;
  localparam int B_W  = 7;
  localparam int B_NW = 8;

  localparam logic [BRAM_SIZE-1:0] LAST_ADDR = BRAM_SIZE'(BRAM_DEPTH - 1);
  localparam logic [XW-1:0]        X_LAST    = XW'(HPIXELS - 1);
  localparam logic [YW-1:0]        Y_LAST    = YW'(VPIXELS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [BRAM_SIZE-1:0] addr_q, addr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  // tag1: read issued last cycle; tag2: its data is on bram_data_in now.
  logic                 tag1_q, tag1_d;
  logic                 tag2_q, tag2_d;
  // Coordinates of the next cell to be pushed (returns arrive in order).
  logic [XW-1:0]        px_q, px_d;
  logic [YW-1:0]        py_q, py_d;
  logic [1:0]           wr_q, wr_d;
  logic [1:0]           rd_q, rd_d;
  logic [2:0]           count_q, count_d;
  logic [7:0]           fpix_q [4];
  logic [7:0]           fpix_d [4];
  logic [XW-1:0]        fx_q [4];
  logic [XW-1:0]        fx_d [4];
  logic [YW-1:0]        fy_q [4];
  logic [YW-1:0]        fy_d [4];

  logic [11:0] sum_all;
  logic [9:0]  east, west, north, south;
  logic [10:0] ux, uy, ux_abs, uy_abs;
  logic [7:0]  pix_calc;
  logic [2:0]  credit_used;
  logic        issue, push, pop;

  function automatic logic [7:0] sat8(input logic [10:0] v);
    return (v > 11'd255) ? 8'hFF : v[7:0];
  endfunction

  // Shading of the cell currently returning from BRAM.
  always_comb begin
    sum_all = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      sum_all = sum_all + 12'(bram_data_in[i]);
    end
    east   = 10'(bram_data_in[B_NE]) + 10'(bram_data_in[B_E]) + 10'(bram_data_in[B_SE]);
    west   = 10'(bram_data_in[B_SW]) + 10'(bram_data_in[B_W]) + 10'(bram_data_in[B_NW]);
    north  = 10'(bram_data_in[B_NW]) + 10'(bram_data_in[B_N]) + 10'(bram_data_in[B_NE]);
    south  = 10'(bram_data_in[B_SE]) + 10'(bram_data_in[B_S]) + 10'(bram_data_in[B_SW]);
    ux     = 11'(east) - 11'(west);
    uy     = 11'(north) - 11'(south);
    ux_abs = ux[10] ? (~ux + 11'd1) : ux;
    uy_abs = uy[10] ? (~uy + 11'd1) : uy;
    case (mode_q)
      2'd1:    pix_calc = sat8(ux_abs);
      2'd2:    pix_calc = sat8(uy_abs);
      default: pix_calc = 8'(sum_all >> 4);
    endcase
  end

  // Next-state: FSM, credit-gated read issue, FIFO push/pop.
  // The shaded result is registered directly into the FIFO slot, so the
  // arithmetic stage register and the FIFO write are the same edge; this
  // gives first valid 4 cycles after start.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    px_d    = px_q;
    py_d    = py_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fpix_d  = fpix_q;
    fx_d    = fx_q;
    fy_d    = fy_q;

    credit_used = count_q + 3'(tag1_q) + 3'(tag2_q);
    issue       = (state_q == READ) && (credit_used < 3'd4);
    push        = tag2_q;
    pop         = pixel_valid_out && pixel_ready_in;
    tag1_d      = issue;
    tag2_d      = tag1_q;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = READ;
          mode_d  = mode_in;
          addr_d  = '0;
          busy_d  = 1'b1;
          px_d    = '0;
          py_d    = '0;
        end
      end
      READ: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) state_d = DRAIN;
          else                     addr_d  = addr_q + BRAM_SIZE'(1);
        end
      end
      DRAIN: begin
        if (pop && fx_q[rd_q] == X_LAST && fy_q[rd_q] == Y_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      fpix_d[wr_q] = pix_calc;
      fx_d[wr_q]   = px_q;
      fy_d[wr_q]   = py_q;
      wr_d         = wr_q + 2'd1;
      if (px_q == X_LAST) begin
        px_d = '0;
        py_d = (py_q == Y_LAST) ? '0 : py_q + YW'(1);
      end else begin
        px_d = px_q + XW'(1);
      end
    end
    if (pop) rd_d = rd_q + 2'd1;
    count_d = count_q + 3'(push) - 3'(pop);
  end

  // State registers; reset also flushes the FIFO and in-flight tags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      mode_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tag1_q  <= 1'b0;
      tag2_q  <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      fpix_q  <= '{default: '0};
      fx_q    <= '{default: '0};
      fy_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      px_q    <= px_d;
      py_q    <= py_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      fpix_q  <= fpix_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
    end
  end

  assign addr_out        = addr_q;
  assign pixel_out       = fpix_q[rd_q];
  assign x_out           = fx_q[rd_q];
  assign y_out           = fy_q[rd_q];
  assign pixel_valid_out = (count_q != 3'd0);
  assign busy_out        = busy_q;
  assign frame_done_out  = done_q;

endmodule

// File: tb/tb_lattice_readout.sv
// Scoreboard bench for lattice_readout on a 4x2 lattice.
module tb_lattice_readout;
  localparam int H = 4;
  localparam int V = 2;
  localparam int D = H * V;
  localparam int C = 0, N = 1, NE = 2, E = 3, SE = 4, S = 5, SW = 6, W = 7, NW = 8;

  logic            clk = 1'b0;
  logic            rst, start, ready;
  logic [1:0]      mode;
  logic [8:0][7:0] bram_data;
  logic [2:0]      addr;
  logic [7:0]      pix;
  logic            valid, busy, done;
  logic [1:0]      x;
  logic [0:0]      y;

  always #5 clk = ~clk;

  lattice_readout #(.HPIXELS(H), .VPIXELS(V)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .mode_in(mode),
    .bram_data_in(bram_data), .addr_out(addr), .pixel_out(pix),
    .pixel_valid_out(valid), .pixel_ready_in(ready), .x_out(x), .y_out(y),
    .busy_out(busy), .frame_done_out(done)
  );

  // BRAM model with 2-cycle read latency.
  logic [8:0][7:0] bmem [D];
  logic [2:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p1 <= addr;
    p2 <= p1;
  end
  assign bram_data = bmem[p2];

  typedef struct packed {
    logic [7:0] pix;
    logic [1:0] x;
    logic [0:0] y;
  } exp_t;
  exp_t q[$];

  int total = 0, bad = 0;
  int done_cnt = 0, xfer_cnt = 0;
  bit mon_en = 0, stall_prev = 0, last_prev = 0;
  logic [7:0] prev_pix;
  logic [1:0] prev_x;
  logic [0:0] prev_y;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < D; a++) bmem[a] = '0;
  endtask

  task automatic set_uniform(input logic [7:0] v);
    for (int a = 0; a < D; a++)
      for (int b = 0; b < 9; b++) bmem[a][b] = v;
  endtask

  task automatic push_exp(input int a, input int p);
    exp_t e;
    e.pix = 8'(p);
    e.x   = 2'(a % H);
    e.y   = 1'(a / H);
    q.push_back(e);
  endtask

  task automatic push_uniform(input int p);
    for (int a = 0; a < D; a++) push_exp(a, p);
  endtask

  task automatic start_frame(input logic [1:0] m, input bit lat);
    int n;
    @(posedge clk); #1 start = 1'b1; mode = m;
    @(posedge clk); #1 start = 1'b0;
    if (lat) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!valid && n < 20);
      chk("first_valid_latency", n, 4);
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      @(negedge clk); #2;
      n++;
    end
    chk("frame_done_count", done_cnt, target);
    repeat (3) @(negedge clk);
    #2;
    chk("frame_done_once", done_cnt, target);
    chk("queue_drained", q.size(), 0);
    chk("busy_after_frame", int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, int'(addr), 0);
    chk({tag, "_pixel"}, int'(pix), 0);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // Monitor: pops the scoreboard on every transfer, checks hold-while-stalled
  // and the frame_done/busy timing after the last cell.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (stall_prev) begin
          chk("hold_valid", int'(valid), 1);
          chk("hold_pixel", int'(pix), int'(prev_pix));
          chk("hold_x", int'(x), int'(prev_x));
          chk("hold_y", int'(y), int'(prev_y));
        end
        if (last_prev) begin
          chk("done_after_last", int'(done), 1);
          chk("busy_drop_after_last", int'(busy), 0);
        end
        stall_prev = 0;
        last_prev  = 0;
        if (done) done_cnt++;
        if (valid && ready) begin
          chk("expected_available", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("pixel", int'(pix), int'(e.pix));
            chk("x", int'(x), int'(e.x));
            chk("y", int'(y), int'(e.y));
          end
          xfer_cnt++;
          if (x == 2'(H - 1) && y == 1'(V - 1)) last_prev = 1;
        end else if (valid) begin
          stall_prev = 1;
          prev_pix   = pix;
          prev_x     = x;
          prev_y     = y;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int base, n, issued, exp_addr;
    rst = 1'b1; start = 1'b0; mode = 2'd0; ready = 1'b1;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    mon_en = 1;

    // Mode 0, uniform 16: 144>>4 = 9 everywhere.
    set_uniform(8'd16);
    push_uniform(9);
    start_frame(2'd0, 1);
    wait_done(1);

    // Mode 1 directed cells.
    clear_mem();
    bmem[0][E] = 200; bmem[0][W] = 10;                    push_exp(0, 190);
    bmem[1][NE] = 255; bmem[1][E] = 255; bmem[1][SE] = 255; push_exp(1, 255);
    bmem[2][SW] = 255; bmem[2][W] = 255; bmem[2][NW] = 255; push_exp(2, 255);
    bmem[3][NE] = 5; bmem[3][W] = 3;                       push_exp(3, 2);
    bmem[4][E] = 10; bmem[4][W] = 30;                      push_exp(4, 20);
    bmem[5][C] = 200; bmem[5][N] = 100; bmem[5][S] = 50;   push_exp(5, 0);
    bmem[6][NE] = 100; bmem[6][SE] = 100; bmem[6][NW] = 60; push_exp(6, 140);
    bmem[7][W] = 1;                                        push_exp(7, 1);
    start_frame(2'd1, 0);
    wait_done(2);

    // Mode 2 directed cells, with a 20-cycle ready stall mid-frame.
    clear_mem();
    bmem[0][S] = 100;                                      push_exp(0, 100);
    bmem[1][N] = 255; bmem[1][NE] = 255; bmem[1][NW] = 255; push_exp(1, 255);
    bmem[2][SE] = 1; bmem[2][S] = 2; bmem[2][SW] = 3;      push_exp(2, 6);
    bmem[3][N] = 200; bmem[3][S] = 100;                    push_exp(3, 100);
    bmem[4][E] = 255; bmem[4][W] = 255; bmem[4][C] = 255;  push_exp(4, 0);
    bmem[5][NW] = 7;                                       push_exp(5, 7);
    bmem[6][SE] = 128; bmem[6][SW] = 128;                  push_exp(6, 255);
    bmem[7][N] = 255;                                      push_exp(7, 255);
    base = xfer_cnt;
    start_frame(2'd2, 0);
    n = 0;
    while (xfer_cnt < base + 1 && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    chk("transfer_before_stall", int'(xfer_cnt >= base + 1), 1);
    @(posedge clk); #1 ready = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    issued   = xfer_cnt - base + 4;
    exp_addr = (issued > D - 1) ? D - 1 : issued;
    chk("outstanding_reads_addr", int'(addr), exp_addr);
    chk("stall_busy", int'(busy), 1);
    chk("stall_valid", int'(valid), 1);
    @(posedge clk); #1 ready = 1'b1;
    wait_done(3);

    // Mode 3 behaves as mode 0; all 255: 2295>>4 = 143.
    set_uniform(8'd255);
    push_uniform(143);
    start_frame(2'd3, 0);
    wait_done(4);

    // start pulsed while busy (with a different mode) must be ignored.
    set_uniform(8'd16);
    push_uniform(9);
    start_frame(2'd0, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 start = 1'b1; mode = 2'd1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_during_ignored_start", int'(busy), 1);
    wait_done(5);

    // Reset mid-frame, then a fresh frame right away.
    push_uniform(9);
    start_frame(2'd0, 0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1 mon_en = 0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    q.delete();
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    set_uniform(8'd32);
    push_uniform(18);
    stall_prev = 0;
    last_prev  = 0;
    mon_en     = 1;
    start_frame(2'd0, 1);
    wait_done(6);

    repeat (5) @(negedge clk);
    #2;
    chk("total_frames_done", done_cnt, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
